// File: rtl/shift_unit_pipe_if.sv
// rtl/shift_unit_pipe_if.sv - request/result handshake bundle for shift_unit_pipe
interface shift_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag
    );

    modport slave (
        input  flush, in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag
    );
endinterface

// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROR) with per-stage backpressure
module shift_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_unit_pipe_if.slave bus
);
    localparam int LVLS  = $clog2(WIDTH);
    localparam int BASE  = LVLS / STAGES;
    localparam int EXTRA = LVLS % STAGES;

    // First network level owned by stage s; earlier stages absorb the remainder.
    function automatic int stage_lo(input int s);
        return s * BASE + ((s < EXTRA) ? s : EXTRA);
    endfunction

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                     input logic [1:0]       op,
                                                     input logic             sgn,
                                                     input int               k);
        int               amt;
        logic [WIDTH-1:0] hi_mask;
        amt     = 1 << k;
        hi_mask = ~({WIDTH{1'b1}} >> amt);
        case (op)
            2'b00:   return x << amt;
            2'b01:   return x >> amt;
            2'b10:   return (x >> amt) | (hi_mask & {WIDTH{sgn}});
            default: return (x >> amt) | (x << (WIDTH - amt));
        endcase
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] sg_q;
    logic [STAGES-1:0] src_sg;
    logic [WIDTH-1:0]  d_q     [STAGES];
    logic [WIDTH-1:0]  d_n     [STAGES];
    logic [WIDTH-1:0]  src_d   [STAGES];
    logic [LVLS-1:0]   sh_q    [STAGES];
    logic [LVLS-1:0]   src_sh  [STAGES];
    logic [1:0]        op_q    [STAGES];
    logic [1:0]        src_op  [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];

    // A stage may advance when it is empty or the stage after it advances.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !v_q[STAGES-1] || bus.out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv[s] = !v_q[s] || adv[s+1];
        end
    end

    // The SRA fill bit is taken from the operand at accept and carried alongside.
    always_comb begin
        vin        = '0;
        src_sg     = '0;
        vin[0]     = bus.in_valid;
        src_d[0]   = bus.in_a;
        src_sh[0]  = bus.in_shamt;
        src_op[0]  = bus.in_op;
        src_tag[0] = bus.in_tag;
        src_sg[0]  = bus.in_a[WIDTH-1];
        for (int s = 1; s < STAGES; s++) begin
            vin[s]     = v_q[s-1];
            src_d[s]   = d_q[s-1];
            src_sh[s]  = sh_q[s-1];
            src_op[s]  = op_q[s-1];
            src_tag[s] = tag_q[s-1];
            src_sg[s]  = sg_q[s-1];
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            d_n[s] = src_d[s];
            for (int k = 0; k < LVLS; k++) begin
                if (k >= stage_lo(s) && k < stage_lo(s + 1) && src_sh[s][k]) begin
                    d_n[s] = shift_level(d_n[s], src_op[s], src_sg[s], k);
                end
            end
        end
    end

    // Payload registers only load with a valid op so bubbles never disturb held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            sg_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s]   <= '0;
                sh_q[s]  <= '0;
                op_q[s]  <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    v_q[s] <= vin[s];
                    if (vin[s]) begin
                        d_q[s]   <= d_n[s];
                        sh_q[s]  <= src_sh[s];
                        op_q[s]  <= src_op[s];
                        tag_q[s] <= src_tag[s];
                        sg_q[s]  <= src_sg[s];
                    end
                end
            end
            if (bus.flush) begin
                v_q <= '0;
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_res   = d_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
endmodule
